// File: rtl/sprite_pkg.sv
// Register map, attribute bit positions and line-fetch states shared by sprite_engine
// and its per-slot sub-module.
package sprite_pkg;

  localparam logic [3:0] OFF_X    = 4'd0;
  localparam logic [3:0] OFF_Y    = 4'd1;
  localparam logic [3:0] OFF_ATTR = 4'd2;
  localparam logic [3:0] OFF_BMP  = 4'd8;

  localparam int unsigned G_COLL  = 0;
  localparam int unsigned G_COUNT = 1;

  localparam int unsigned ATTR_EN      = 7;
  localparam int unsigned ATTR_HFLIP   = 4;
  localparam int unsigned ATTR_COL_MSB = 3;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE
  } fetch_state_e;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/sprite_slot.sv
// One sprite slot: X/Y/ATTR/bitmap registers, the row latch filled by the line fetch,
// and the per-pixel hit test driving pix_on_o.
module sprite_slot
  import sprite_pkg::*;
#(
  parameter int unsigned SW = 8,
  parameter int unsigned SH = 8
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       we_i,
  input  logic [3:0] off_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o,
  input  logic       fetch_i,
  input  logic [6:0] line_i,
  input  logic       vclr_i,
  input  logic [7:0] hpos_i,
  output logic       pix_on_o,
  output logic [3:0] color_o
);

  logic [7:0] x_q, y_q, attr_q;
  logic [7:0] bmp_q [SH];
  logic [7:0] row_q, row_d;
  logic [7:0] row_idx, bmp_sel;
  logic       row_vis;
  logic [8:0] dx;
  logic       hit;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      x_q    <= '0;
      y_q    <= '0;
      attr_q <= '0;
      for (int unsigned r = 0; r < SH; r++) begin
        bmp_q[r] <= '0;
      end
    end else if (we_i) begin
      case (off_i)
        OFF_X:    x_q    <= wdata_i;
        OFF_Y:    y_q    <= wdata_i;
        OFF_ATTR: attr_q <= wdata_i;
        default: begin
          for (int unsigned r = 0; r < SH; r++) begin
            if (off_i == OFF_BMP + 4'(r)) bmp_q[r] <= wdata_i;
          end
        end
      endcase
    end
  end

  always_comb begin
    rdata_o = '0;
    case (off_i)
      OFF_X:    rdata_o = x_q;
      OFF_Y:    rdata_o = y_q;
      OFF_ATTR: rdata_o = attr_q;
      default: begin
        for (int unsigned r = 0; r < SH; r++) begin
          if (off_i == OFF_BMP + 4'(r)) rdata_o = bmp_q[r];
        end
      end
    endcase
  end

  // Row offset wraps in 8 bits, so lines above Y land far above SH and are rejected.
  always_comb begin
    row_idx = {1'b0, line_i} - y_q;
    bmp_sel = '0;
    for (int unsigned r = 0; r < SH; r++) begin
      if (row_idx == 8'(r)) bmp_sel = bmp_q[r];
    end
    row_vis = attr_q[ATTR_EN] && (row_idx < 8'(SH));
    row_d   = row_q;
    if (vclr_i) begin
      row_d = '0;
    end else if (fetch_i) begin
      if (!row_vis) row_d = '0;
      else if (attr_q[ATTR_HFLIP]) row_d = rev8(bmp_sel);
      else row_d = bmp_sel;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) row_q <= '0;
    else row_q <= row_d;
  end

  always_comb begin
    dx       = {1'b0, hpos_i} - {1'b0, x_q};
    hit      = (hpos_i >= x_q) && (dx < 9'(SW));
    pix_on_o = hit && row_q[3'd7 - dx[2:0]];
    color_o  = attr_q[ATTR_COL_MSB:0];
  end

endmodule

// File: rtl/sprite_engine.sv
// Multi-sprite generator: CPU register decode, per-line fetch FSM, priority encoder and
// optional sticky collision register (enabled by SPRITE_ENGINE_COLLISION_EN).
module sprite_engine
  import sprite_pkg::*;
#(
  parameter int unsigned NSPRITES = 4,
  parameter int unsigned SW       = 8,
  parameter int unsigned SH       = 8,
  parameter int unsigned AW       = $clog2(NSPRITES) + 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] addr,
  input  logic          cs,
  input  logic          rw,
  input  logic [7:0]    di,
  output logic [7:0]    dout,
  input  logic [7:0]    hpos,
  input  logic [6:0]    vpos,
  input  logic          hsync,
  input  logic          vsync,
  output logic [3:0]    color,
  output logic          opaque
);

  localparam int unsigned KW = (NSPRITES > 1) ? $clog2(NSPRITES) : 1;

  logic          is_global;
  logic [AW-2:0] low, slot_sel;
  logic [3:0]    off;

  fetch_state_e  state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [6:0]    line_q, line_d;
  logic          hsync_q, hs_rise;

  logic [NSPRITES-1:0] pix_on, we, fetch;
  logic [3:0]          col   [NSPRITES];
  logic [7:0]          rdata [NSPRITES];
  logic [3:0]          color_q, color_d;
  logic                opaque_q, opaque_d;
  logic [7:0]          coll_rdata;

  always_comb begin
    is_global = addr[AW-1];
    low       = addr[AW-2:0];
    slot_sel  = low >> 4;
    off       = addr[3:0];
    hs_rise   = hsync && !hsync_q;
  end

  for (genvar k = 0; k < NSPRITES; k++) begin : g_slot
    assign we[k]    = cs && !rw && !is_global && (slot_sel == (AW-1)'(k));
    assign fetch[k] = (state_q == FETCH) && (k_q == KW'(k));

    sprite_slot #(
      .SW (SW),
      .SH (SH)
    ) u_slot (
      .clk_i    (clk),
      .reset_i  (reset),
      .we_i     (we[k]),
      .off_i    (off),
      .wdata_i  (di),
      .rdata_o  (rdata[k]),
      .fetch_i  (fetch[k]),
      .line_i   (line_q),
      .vclr_i   (vsync),
      .hpos_i   (hpos),
      .pix_on_o (pix_on[k]),
      .color_o  (col[k])
    );
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    line_d  = line_q;
    if (vsync) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (hs_rise) begin
            state_d = FETCH;
            k_d     = '0;
            line_d  = vpos + 7'd1;
          end
        end
        FETCH: begin
          if (k_q == KW'(NSPRITES - 1)) state_d = DONE;
          else k_d = k_q + KW'(1);
        end
        DONE: begin
          if (!hsync) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      line_q  <= '0;
      hsync_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      line_q  <= line_d;
      hsync_q <= hsync;
    end
  end

  always_comb begin
    color_d  = '0;
    opaque_d = 1'b0;
    for (int unsigned i = 0; i < NSPRITES; i++) begin
      if (pix_on[i] && !opaque_d) begin
        opaque_d = 1'b1;
        color_d  = col[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      color_q  <= '0;
      opaque_q <= 1'b0;
    end else begin
      color_q  <= color_d;
      opaque_q <= opaque_d;
    end
  end

  assign color  = color_q;
  assign opaque = opaque_q;

`ifdef SPRITE_ENGINE_COLLISION_EN
  logic [NSPRITES-1:0] coll_q, coll_d, coll_set;
  logic                coll_rd, multi;

  // Clearing the lowest set bit leaves something only when two or more sprites are on.
  always_comb begin
    multi    = |(pix_on & (pix_on - NSPRITES'(1)));
    coll_set = multi ? pix_on : '0;
    coll_rd  = cs && rw && is_global && (low == (AW-1)'(G_COLL));
    coll_d   = coll_rd ? '0 : coll_q;
    coll_d   = coll_d | coll_set;
  end

  always_ff @(posedge clk) begin
    if (reset) coll_q <= '0;
    else coll_q <= coll_d;
  end

  assign coll_rdata = 8'(coll_q);
`else
  assign coll_rdata = '0;
`endif

  always_comb begin
    dout = '0;
    if (is_global) begin
      if (low == (AW-1)'(G_COLL)) dout = coll_rdata;
      else if (low == (AW-1)'(G_COUNT)) dout = 8'(NSPRITES);
    end else begin
      for (int unsigned k = 0; k < NSPRITES; k++) begin
        if (slot_sel == (AW-1)'(k)) dout = rdata[k];
      end
    end
  end

endmodule

// File: tb/tb_sprite_engine.sv
// Directed and randomized bench for sprite_engine against a line/pixel reference model.
module tb_sprite_engine;

  localparam int unsigned N  = 4;
  localparam int unsigned SH = 8;
  localparam int unsigned AW = 7;
`ifdef SPRITE_ENGINE_COLLISION_EN
  localparam bit COLL_EN = 1'b1;
`else
  localparam bit COLL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0, cs = 1'b0, rw = 1'b0, hsync = 1'b0, vsync = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [7:0]    di = '0, dout, hpos = 8'd200;
  logic [6:0]    vpos = '0;
  logic [3:0]    color;
  logic          opaque;

  int checks = 0;
  int failures = 0;

  int mX [N];
  int mY [N];
  int mA [N];
  int mB [N][SH];
  int mL [N];
  bit mF [N];
  int mColl;

  always #5 clk = ~clk;

  sprite_engine #(
    .NSPRITES (N),
    .SW       (8),
    .SH       (SH)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .cs     (cs),
    .rw     (rw),
    .di     (di),
    .dout   (dout),
    .hpos   (hpos),
    .vpos   (vpos),
    .hsync  (hsync),
    .vsync  (vsync),
    .color  (color),
    .opaque (opaque)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin
      mX[k] = 0; mY[k] = 0; mA[k] = 0; mL[k] = 0; mF[k] = 1'b0;
      for (int r = 0; r < SH; r++) mB[k][r] = 0;
    end
    mColl = 0;
  endfunction

  function automatic void model_write(input int a, input int d);
    int slot, off;
    if (a >= 64) return;
    slot = a / 16;
    off  = a % 16;
    if (slot >= N) return;
    if (off == 0) mX[slot] = d;
    else if (off == 1) mY[slot] = d;
    else if (off == 2) mA[slot] = d;
    else if (off >= 8 && off < 8 + SH) mB[slot][off-8] = d;
  endfunction

  function automatic int model_read(input int a);
    int slot, off;
    if (a >= 64) begin
      off = a - 64;
      if (off == 0) return COLL_EN ? mColl : 0;
      if (off == 1) return N;
      return 0;
    end
    slot = a / 16;
    off  = a % 16;
    if (slot >= N) return 0;
    if (off == 0) return mX[slot];
    if (off == 1) return mY[slot];
    if (off == 2) return mA[slot];
    if (off >= 8 && off < 8 + SH) return mB[slot][off-8];
    return 0;
  endfunction

  // Latch the unflipped row and the flip flag; the flip is applied at pixel time.
  function automatic void model_fetch(input int v);
    int line, row;
    line = (v + 1) % 128;
    for (int k = 0; k < N; k++) begin
      row = (line - mY[k]) & 255;
      if (mA[k][7] && row < SH) begin
        mL[k] = mB[k][row];
        mF[k] = mA[k][4];
      end else begin
        mL[k] = 0;
        mF[k] = 1'b0;
      end
    end
  endfunction

  task automatic cpu_write(input int a, input int d);
    @(negedge clk);
    addr = AW'(a); di = 8'(d); cs = 1'b1; rw = 1'b0;
    @(posedge clk);
    #1;
    model_write(a, d & 255);
    cs = 1'b0;
  endtask

  task automatic cpu_read(input int a, input string tag);
    @(negedge clk);
    addr = AW'(a); cs = 1'b1; rw = 1'b1;
    #1;
    check(tag, 32'(dout), 32'(model_read(a)));
    @(posedge clk);
    #1;
    if (a == 64 && COLL_EN) mColl = 0;
    cs = 1'b0; rw = 1'b0;
  endtask

  task automatic scan(input int h, input string tag);
    int cnt, mask, ecol, c, b;
    @(negedge clk);
    hpos = 8'(h);
    @(posedge clk);
    #1;
    cnt = 0; mask = 0; ecol = 0;
    for (int k = 0; k < N; k++) begin
      if (h >= mX[k] && h - mX[k] < 8) begin
        c = h - mX[k];
        b = mF[k] ? mL[k][c] : mL[k][7-c];
        if (b != 0) begin
          if (cnt == 0) ecol = mA[k] & 15;
          cnt++;
          mask |= (1 << k);
        end
      end
    end
    if (COLL_EN && cnt >= 2) mColl |= mask;
    check($sformatf("%s_opaque_h%0d", tag, h), 32'(opaque), 32'(cnt > 0));
    if (cnt > 0) check($sformatf("%s_color_h%0d", tag, h), 32'(color), 32'(ecol));
  endtask

  task automatic fetch_line(input int v);
    @(negedge clk);
    vpos = 7'(v); hsync = 1'b1;
    if (!vsync) model_fetch(v);
    repeat (N + 3) @(posedge clk);
    #1;
    hsync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic set_vsync(input bit v);
    @(negedge clk);
    vsync = v;
    @(posedge clk);
    #1;
    if (v) for (int k = 0; k < N; k++) begin mL[k] = 0; mF[k] = 1'b0; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; hsync = 1'b0; cs = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int v, line, x0;
    model_reset();
    do_reset();

    // reset state and global space
    cpu_read(8'h00, "rst_x0");
    cpu_read(8'h01, "rst_y0");
    cpu_read(8'h02, "rst_attr0");
    cpu_read(8'h08, "rst_bmp0");
    cpu_read(8'h40, "rst_coll");
    cpu_read(8'h41, "count");
    check("count_const", 32'(dout), 32'(N));
    cpu_read(8'h42, "glob_other");
    check("rst_opaque", 32'(opaque), 32'd0);
    check("rst_color", 32'(color), 32'd0);

    // basic hit
    cpu_write(8'h00, 10); cpu_write(8'h01, 20); cpu_write(8'h02, 8'h89); cpu_write(8'h08, 8'h80);
    cpu_write(8'h03, 8'h55); cpu_read(8'h03, "reserved");
    fetch_line(19);
    scan(10, "basic");
    check("basic_const_op", 32'(opaque), 32'd1);
    check("basic_const_col", 32'(color), 32'd9);
    scan(11, "basic");
    check("basic_const_off", 32'(opaque), 32'd0);
    scan(9, "basic");
    scan(200, "park");

    // horizontal flip
    cpu_write(8'h08, 8'h01); cpu_write(8'h02, 8'h99);
    fetch_line(19);
    scan(10, "hflip");
    check("hflip_const_on", 32'(opaque), 32'd1);
    scan(17, "hflip");
    check("hflip_const_off", 32'(opaque), 32'd0);
    scan(200, "park");

    // priority and collision
    cpu_write(8'h00, 40); cpu_write(8'h02, 8'h89); cpu_write(8'h08, 8'hFF);
    cpu_write(8'h10, 40); cpu_write(8'h11, 20); cpu_write(8'h12, 8'h83); cpu_write(8'h18, 8'hFF);
    fetch_line(19);
    for (int h = 40; h < 48; h++) scan(h, "prio");
    check("prio_const_col", 32'(color), 32'd9);
    scan(200, "park");
    cpu_read(8'h40, "coll_first");
    if (COLL_EN) check("coll_first_const", 32'(mColl), 32'd0);
    cpu_read(8'h40, "coll_second");
    cpu_write(8'h12, 8'h03);
    fetch_line(19);
    for (int h = 40; h < 48; h++) scan(h, "solo");
    scan(200, "park");
    cpu_read(8'h40, "coll_after_disable");

    // right-edge clipping and disable
    cpu_write(8'h00, 252);
    fetch_line(19);
    for (int h = 248; h < 256; h++) scan(h, "clip");
    for (int h = 0; h < 4; h++) scan(h, "clipwrap");
    cpu_write(8'h02, 8'h09);
    fetch_line(19);
    for (int h = 250; h < 256; h++) scan(h, "dis");
    scan(200, "park");

    // reset in the middle of a fetch
    cpu_write(8'h00, 10); cpu_write(8'h02, 8'h89); cpu_write(8'h08, 8'h80);
    @(negedge clk);
    vpos = 7'd19; hsync = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    scan(10, "midrst");
    cpu_read(8'h00, "midrst_x0");
    cpu_read(8'h02, "midrst_attr0");
    cpu_read(8'h08, "midrst_bmp0");
    cpu_read(8'h12, "midrst_attr1");

    // vsync clears latches and blocks fetch until the next line
    cpu_write(8'h00, 10); cpu_write(8'h01, 20); cpu_write(8'h02, 8'h89); cpu_write(8'h08, 8'h80);
    fetch_line(19);
    scan(10, "prevs");
    set_vsync(1'b1);
    scan(10, "vs");
    fetch_line(19);
    scan(10, "vs_fetch");
    set_vsync(1'b0);
    scan(10, "postvs");
    check("postvs_const", 32'(opaque), 32'd0);
    fetch_line(19);
    scan(10, "refetch");
    check("refetch_const", 32'(opaque), 32'd1);

    // randomized sprite sets, lines and pixels
    for (int it = 0; it < 20; it++) begin
      v = $urandom_range(0, 127);
      line = (v + 1) % 128;
      for (int k = 0; k < N; k++) begin
        cpu_write(k * 16 + 0, $urandom_range(0, 255));
        cpu_write(k * 16 + 1, (line - $urandom_range(0, 10)) & 255);
        cpu_write(k * 16 + 2, ($urandom_range(0, 3) != 0 ? 8'h80 : 8'h00) | ($urandom & 8'h7F));
        for (int r = 0; r < SH; r++) cpu_write(k * 16 + 8 + r, $urandom_range(0, 255));
      end
      cpu_write($urandom_range(0, 63), $urandom_range(0, 255));
      cpu_write($urandom_range(65, 127), $urandom_range(0, 255));
      cpu_read($urandom_range(0, 63), $sformatf("rnd_rd_%0d", it));
      if (it % 5 == 4) begin
        set_vsync(1'b1);
        fetch_line(v);
        scan($urandom_range(0, 255), "rnd_vs");
        set_vsync(1'b0);
      end else begin
        fetch_line(v);
      end
      x0 = mX[0];
      for (int c = 0; c < 9; c++) if (x0 + c < 256) scan(x0 + c, $sformatf("rnd%0d_s0", it));
      for (int j = 0; j < 16; j++) scan($urandom_range(0, 255), $sformatf("rnd%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
